// File: rtl/bpsk_ctrl_pkg.sv
// ============================================================================
// bpsk_ctrl_pkg : shared types and defaults for the BPSK frame controllers
// Revision 1.0
// ============================================================================
`default_nettype none

package bpsk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GUARD    = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hD3;
  // 5 MHz system clock / 1 kbit/s line rate
  localparam int         BIT_CYCLES_5MHZ   = 5000;

  function automatic state_e next_state(input state_e s);
    case (s)
      ST_PREAMBLE: return ST_SYNC;
      ST_SYNC:     return ST_PAYLOAD;
      ST_PAYLOAD:  return ST_GUARD;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpsk_tx_controller_bit_timer.sv
// ============================================================================
// bit_timer : per-bit cycle counter with first/last-cycle flags
// Revision 1.0
// ============================================================================
`default_nettype none

module bit_timer #(
  parameter int BIT_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_first,
  output logic bit_last
);

  logic [15:0] cyc_cnt_q;
  logic [15:0] cyc_cnt_d;

  assign bit_first = (cyc_cnt_q == 16'd0);
  assign bit_last  = (cyc_cnt_q == 16'(BIT_CYCLES - 1));

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (clr) begin
      cyc_cnt_d = 16'd0;
    end else if (en) begin
      cyc_cnt_d = bit_last ? 16'd0 : cyc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= 16'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpsk_tx_controller.sv
// ============================================================================
// bpsk_tx_controller : pushbutton-triggered BPSK frame sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module bpsk_tx_controller
  import bpsk_ctrl_pkg::*;
#(
  parameter int         BIT_CYCLES    = BIT_CYCLES_5MHZ,
  parameter int         PREAMBLE_BITS = 16,
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int         GUARD_BITS    = 4
) (
  input  logic       Myclk,
  input  logic       Myrst_n,
  input  logic       PB_db,
  input  logic [7:0] tx_data,
  input  logic       abort,
  output logic       busy,
  output logic       carrier_en,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       done,
  output logic [7:0] frame_cnt
);

  state_e     state_q,     state_d;
  logic [7:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] shift_q,     shift_d;
  logic       pb_q,        pb_d;
  logic       done_q,      done_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic       start;
  logic [7:0] last_bit;
  logic       bit_first;
  logic       bit_last;

  // Idle holds the timer at zero so the first bit of a frame starts clean.
  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk       (Myclk),
    .rst_n     (Myrst_n),
    .clr       ((state_q == ST_IDLE) | abort),
    .en        (1'b1),
    .bit_first (bit_first),
    .bit_last  (bit_last)
  );

  always_comb begin
    last_bit = 8'd0;
    case (state_q)
      ST_PREAMBLE:         last_bit = 8'(PREAMBLE_BITS - 1);
      ST_SYNC, ST_PAYLOAD: last_bit = 8'd7;
      ST_GUARD:            last_bit = 8'(GUARD_BITS - 1);
      default:             last_bit = 8'd0;
    endcase
  end

  always_comb begin
    start       = PB_db & ~pb_q;
    pb_d        = PB_db;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (abort) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        state_d   = ST_PREAMBLE;
        bit_cnt_d = 8'd0;
        shift_d   = tx_data;
      end
    end else if (bit_last) begin
      if (state_q == ST_PAYLOAD) begin
        shift_d = {shift_q[6:0], 1'b0};
      end
      if (bit_cnt_q == last_bit) begin
        state_d   = next_state(state_q);
        bit_cnt_d = 8'd0;
        if (state_q == ST_GUARD) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 8'd1;
      end
    end
  end

  // pb_q resets high so a button already held at reset release is not a start.
  always_ff @(posedge Myclk or negedge Myrst_n) begin
    if (!Myrst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 8'd0;
      shift_q     <= 8'd0;
      pb_q        <= 1'b1;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pb_q        <= pb_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign carrier_en = busy & (state_q != ST_GUARD);
  assign bit_strobe = bit_first & carrier_en;
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    bit_out = 1'b0;
    case (state_q)
      ST_PREAMBLE: bit_out = ~bit_cnt_q[0];
      ST_SYNC:     bit_out = SYNC_WORD[~bit_cnt_q[2:0]];
      ST_PAYLOAD:  bit_out = shift_q[7];
      default:     bit_out = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bpsk_tx_controller.sv
// ============================================================================
// tb_bpsk_tx_controller : frame-level model plus directed scenarios
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bpsk_tx_controller;

  localparam int         BC        = 4;
  localparam int         PB        = 4;
  localparam int         GB        = 2;
  localparam int         FRAME_LEN = (PB + 16 + GB) * BC;
  localparam logic [7:0] SYNC      = 8'hD3;

  logic       Myclk;
  logic       Myrst_n;
  logic       PB_db;
  logic [7:0] tx_data;
  logic       abort;
  logic       busy;
  logic       carrier_en;
  logic       bit_out;
  logic       bit_strobe;
  logic       done;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  bpsk_tx_controller #(
    .BIT_CYCLES    (BC),
    .PREAMBLE_BITS (PB),
    .SYNC_WORD     (SYNC),
    .GUARD_BITS    (GB)
  ) dut (
    .Myclk      (Myclk),
    .Myrst_n    (Myrst_n),
    .PB_db      (PB_db),
    .tx_data    (tx_data),
    .abort      (abort),
    .busy       (busy),
    .carrier_en (carrier_en),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .done       (done),
    .frame_cnt  (frame_cnt)
  );

  initial Myclk = 1'b0;
  always #5 Myclk = ~Myclk;

  // Frame model: just "active or not" and a cycle index into the frame.
  logic       m_active;
  int         m_k;
  logic [7:0] m_data;
  logic       m_pbq;
  logic       m_done;
  logic [7:0] m_cnt;

  always @(posedge Myclk or negedge Myrst_n) begin
    if (!Myrst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_data   <= 8'd0;
      m_pbq    <= 1'b1;
      m_done   <= 1'b0;
      m_cnt    <= 8'd0;
    end else begin
      m_pbq  <= PB_db;
      m_done <= 1'b0;
      if (m_active) begin
        if (abort) begin
          m_active <= 1'b0;
          m_k      <= 0;
        end else if (m_k == FRAME_LEN - 1) begin
          m_active <= 1'b0;
          m_k      <= 0;
          m_done   <= 1'b1;
          m_cnt    <= m_cnt + 8'd1;
        end else begin
          m_k <= m_k + 1;
        end
      end else if (PB_db && !m_pbq && !abort) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_data   <= tx_data;
      end
    end
  end

  function automatic logic [12:0] model_out();
    int   idx;
    logic car;
    logic b;
    if (!m_active) return {5'b00000 | {4'b0000, m_done}, m_cnt};
    idx = m_k / BC;
    car = (idx < PB + 16);
    b   = 1'b0;
    if (idx < PB)           b = (idx % 2 == 0);
    else if (idx < PB + 8)  b = SYNC[7 - (idx - PB)];
    else if (idx < PB + 16) b = m_data[7 - (idx - PB - 8)];
    return {1'b1, car, b, car && (m_k % BC == 0), 1'b0, m_cnt};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle passes through here, so the model is compared on all of them.
  task automatic tick();
    logic [12:0] a;
    logic [12:0] e;
    @(negedge Myclk);
    a = {busy, carrier_en, bit_out, bit_strobe, done, frame_cnt};
    e = model_out();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle got=%b want=%b t=%0t", a, e, $time);
    end
  endtask

  task automatic press();
    tick();
    PB_db = 1'b0;
    tick();
    PB_db = 1'b1;
  endtask

  task automatic measure(input int n, input int abort_at, input int rise_at,
                         output int busy_n, output int nocar_n, output int strobes,
                         output int done_n, output int done_at, output int first_busy,
                         output logic [19:0] seq);
    busy_n = 0; nocar_n = 0; strobes = 0; done_n = 0; done_at = 0; first_busy = 0;
    seq = 20'd0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (busy) begin
        busy_n++;
        if (first_busy == 0) first_busy = c;
        if (!carrier_en) nocar_n++;
      end
      if (bit_strobe) begin
        strobes++;
        seq = {seq[18:0], bit_out};
      end
      if (done) begin
        done_n++;
        done_at = c;
      end
      if (c == 3) tx_data = ~tx_data;
      if (abort_at != 0 && c == abort_at)     abort = 1'b1;
      if (abort_at != 0 && c == abort_at + 1) abort = 1'b0;
      if (rise_at != 0 && c == rise_at)       PB_db = 1'b0;
      if (rise_at != 0 && c == rise_at + 2)   PB_db = 1'b1;
    end
  endtask

  int         bn, ncn, sn, dn, da, fb, idle;
  logic [19:0] sq;

  initial begin
    Myrst_n = 1'b0;
    PB_db   = 1'b1;
    tx_data = 8'h00;
    abort   = 1'b0;
    repeat (3) tick();
    Myrst_n = 1'b1;

    // Button held through reset release must not start a frame.
    bn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) bn++;
    end
    check("no_start_held_pb", bn, 0);
    check("reset_frame_cnt", frame_cnt, 0);

    // Full frame with payload A5
    tx_data = 8'hA5;
    press();
    measure(95, 0, 0, bn, ncn, sn, dn, da, fb, sq);
    check("f1_first_busy", fb, 1);
    check("f1_busy_len", bn, 88);
    check("f1_guard_len", ncn, 8);
    check("f1_strobes", sn, 20);
    check("f1_bits", int'(sq), 'hAD3A5);
    check("f1_done_n", dn, 1);
    check("f1_done_at", da, 89);
    check("f1_frame_cnt", frame_cnt, 1);

    // Second rise mid-frame is ignored
    tx_data = 8'h5A;
    press();
    measure(95, 0, 20, bn, ncn, sn, dn, da, fb, sq);
    check("f2_busy_len", bn, 88);
    check("f2_bits", int'(sq), 'hAD35A);
    check("f2_done_n", dn, 1);
    check("f2_frame_cnt", frame_cnt, 2);

    // Abort in payload bit 3
    tx_data = 8'hC3;
    press();
    measure(70, 61, 0, bn, ncn, sn, dn, da, fb, sq);
    check("ab_busy_len", bn, 61);
    check("ab_done_n", dn, 0);
    check("ab_outputs", int'({busy, carrier_en, bit_out, bit_strobe, done}), 0);
    check("ab_frame_cnt", frame_cnt, 2);
    press();
    measure(95, 0, 0, bn, ncn, sn, dn, da, fb, sq);
    check("ab_refr_busy_len", bn, 88);
    check("ab_refr_done_n", dn, 1);
    check("ab_refr_frame_cnt", frame_cnt, 3);

    // Abort beats a simultaneous start
    tick();
    PB_db = 1'b0;
    tick();
    PB_db = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_vs_start", busy, 0);
    tick();
    check("abort_vs_start_late", busy, 0);

    // Async reset in SYNC
    press();
    measure(30, 0, 0, bn, ncn, sn, dn, da, fb, sq);
    #2 Myrst_n = 1'b0;
    #1;
    check("rst_outputs", int'({busy, carrier_en, bit_out, bit_strobe, done}), 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (3) tick();
    Myrst_n = 1'b1;
    repeat (5) tick();
    check("rst_idle_busy", busy, 0);
    check("rst_idle_cnt", frame_cnt, 0);

    // 256 back-to-back frames, each restarted in its done cycle
    press();
    dn = 0;
    idle = 0;
    for (int c = 0; c < 256 * (FRAME_LEN + 1) + 20 && dn < 256; c++) begin
      tick();
      if (!busy) idle++;
      if (done) begin
        dn++;
        PB_db = (dn < 256);
      end else begin
        PB_db = 1'b0;
      end
    end
    check("b2b_done_n", dn, 256);
    check("b2b_idle_cycles", idle, 256);
    check("b2b_frame_cnt_wrap", frame_cnt, 0);
    repeat (4) tick();
    check("b2b_quiet", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
